control_pipeline: RTL and testbench

Pipelined control unit for the RV32I 5-stage CPU. It decodes the one-hot instruction-class flags produced in ID into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also performs load-use and RAW hazard detection (stall), branch/jump flush, and EX operand forwarding selection. It replaces the purely combinational decoder and sits between the ID-stage instruction splitter and the EX/MEM/WB datapath muxes.

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/control_decoder_core.sv | 100 ++++++++++
 rtl/control_pipeline.sv | 171 +++++++++++++++++
 tb/tb_control_pipeline.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the RV32I pipelined control unit.
//   - Encodings for the EX-stage select fields (alu_a, imm, next-pc, alu_op)
//     and for the forwarding mux selects.
//   - Bit positions of the one-hot instruction-class vector from ID.
//   - Packed control bundles carried through ID/EX, EX/MEM and MEM/WB.
package ctrl_pkg;

    localparam int CLASS_W = 9;

    // Bit index of each instruction class inside id_class (bit 0 = r).
    localparam int CLS_R     = 0;
    localparam int CLS_LW    = 1;
    localparam int CLS_ADDI  = 2;
    localparam int CLS_JALR  = 3;
    localparam int CLS_S     = 4;
    localparam int CLS_SB    = 5;
    localparam int CLS_AUIPC = 6;
    localparam int CLS_LUI   = 7;
    localparam int CLS_UJ    = 8;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_e;

    typedef enum logic [1:0] {
        NPC_PC4  = 2'd0,
        NPC_BR   = 2'd1,
        NPC_JAL  = 2'd2,
        NPC_JALR = 2'd3
    } npc_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_FUNCT = 3'd1,
        ALU_CMP   = 3'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_e;

    typedef struct packed {
        alu_a_e  alu_a_sel;
        logic    alu_b_sel;    // 1: immediate, 0: rs2
        imm_e    imm_sel;
        npc_e    next_pc_sel;
        alu_op_e alu_op;
        logic    branch;
    } ctrl_ex_t;

    typedef struct packed {
        logic load;
        logic store;
    } ctrl_mem_t;

    typedef struct packed {
        logic write;           // register-file write enable
        logic load;            // write-back selects load data
    } ctrl_wb_t;

endpackage

// File: rtl/control_decoder_core.sv
// control_decoder_core: pure combinational decode of the one-hot class flags.
// Ports:
//   id_class          in   one-hot instruction class from ID
//   ex_ctrl/mem_ctrl/wb_ctrl  out  control bundles (all-zero when illegal)
//   use_rs1, use_rs2  out  instruction actually reads that source register
//   illegal           out  id_class is zero-hot or multi-hot
module control_decoder_core
    import ctrl_pkg::*;
(
    input  logic [CLASS_W-1:0] id_class,
    output ctrl_ex_t           ex_ctrl,
    output ctrl_mem_t          mem_ctrl,
    output ctrl_wb_t           wb_ctrl,
    output logic               use_rs1,
    output logic               use_rs2,
    output logic               illegal
);

    logic one_hot;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign one_hot = (id_class != '0) &&
                     ((id_class & (id_class - CLASS_W'(1))) == '0);
    assign illegal = !one_hot;

    always_comb begin
        ex_ctrl  = '0;
        mem_ctrl = '0;
        wb_ctrl  = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        if (one_hot) begin
            case (1'b1)
                id_class[CLS_R]: begin
                    wb_ctrl.write  = 1'b1;
                    ex_ctrl.alu_op = ALU_FUNCT;
                    use_rs1        = 1'b1;
                    use_rs2        = 1'b1;
                end
                id_class[CLS_LW]: begin
                    wb_ctrl.write     = 1'b1;
                    wb_ctrl.load      = 1'b1;
                    mem_ctrl.load     = 1'b1;
                    ex_ctrl.alu_b_sel = 1'b1;
                    ex_ctrl.imm_sel   = IMM_I;
                    use_rs1           = 1'b1;
                end
                id_class[CLS_ADDI]: begin
                    wb_ctrl.write     = 1'b1;
                    ex_ctrl.alu_b_sel = 1'b1;
                    ex_ctrl.imm_sel   = IMM_I;
                    ex_ctrl.alu_op    = ALU_FUNCT;
                    use_rs1           = 1'b1;
                end
                id_class[CLS_JALR]: begin
                    wb_ctrl.write       = 1'b1;
                    ex_ctrl.alu_b_sel   = 1'b1;
                    ex_ctrl.imm_sel     = IMM_I;
                    ex_ctrl.next_pc_sel = NPC_JALR;
                    use_rs1             = 1'b1;
                end
                id_class[CLS_S]: begin
                    mem_ctrl.store    = 1'b1;
                    ex_ctrl.alu_b_sel = 1'b1;
                    ex_ctrl.imm_sel   = IMM_S;
                    use_rs1           = 1'b1;
                    use_rs2           = 1'b1;
                end
                id_class[CLS_SB]: begin
                    ex_ctrl.branch      = 1'b1;
                    ex_ctrl.imm_sel     = IMM_B;
                    ex_ctrl.next_pc_sel = NPC_BR;
                    ex_ctrl.alu_op      = ALU_CMP;
                    use_rs1             = 1'b1;
                    use_rs2             = 1'b1;
                end
                id_class[CLS_AUIPC]: begin
                    wb_ctrl.write     = 1'b1;
                    ex_ctrl.alu_a_sel = ALU_A_PC;
                    ex_ctrl.alu_b_sel = 1'b1;
                    ex_ctrl.imm_sel   = IMM_U;
                end
                id_class[CLS_LUI]: begin
                    wb_ctrl.write     = 1'b1;
                    ex_ctrl.alu_a_sel = ALU_A_ZERO;
                    ex_ctrl.alu_b_sel = 1'b1;
                    ex_ctrl.imm_sel   = IMM_U;
                end
                id_class[CLS_UJ]: begin
                    wb_ctrl.write       = 1'b1;
                    ex_ctrl.alu_a_sel   = ALU_A_PC;
                    ex_ctrl.imm_sel     = IMM_J;
                    ex_ctrl.next_pc_sel = NPC_JAL;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: decode + ID/EX, EX/MEM, MEM/WB control registers with
// hazard detection, flush and EX operand forwarding selection.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid, id_class       ID holds a real instruction / its one-hot class
//   id_rs1, id_rs2, id_rd    register indices in ID
//   flush                    taken branch/jump in EX: discard the ID instruction
//   stall                    hold PC and IF/ID, bubble into ID/EX
//   illegal                  EX slot holds a zero-hot or multi-hot decode
//   ex_ctrl, fwd_a, fwd_b    EX-stage controls and operand forwarding selects
//   mem_ctrl                 MEM-stage load/store
//   wb_write, wb_load, wb_rd write-back controls
// A stage "valid" bit marks a real instruction; there is no backpressure other
// than stall, which only affects the ID -> EX transfer.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [CLASS_W-1:0]    id_class,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  illegal,
    output ctrl_ex_t              ex_ctrl,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output ctrl_mem_t             mem_ctrl,
    output logic                  wb_write,
    output logic                  wb_load,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    ctrl_ex_t  dec_ex;
    ctrl_mem_t dec_mem;
    ctrl_wb_t  dec_wb_raw;
    ctrl_wb_t  dec_wb;
    logic      dec_use1, dec_use2, dec_illegal;

    control_decoder_core u_decoder (
        .id_class (id_class),
        .ex_ctrl  (dec_ex),
        .mem_ctrl (dec_mem),
        .wb_ctrl  (dec_wb_raw),
        .use_rs1  (dec_use1),
        .use_rs2  (dec_use2),
        .illegal  (dec_illegal)
    );

    // Writes to x0 are dropped at decode so x0 never looks like a producer.
    always_comb begin
        dec_wb       = dec_wb_raw;
        dec_wb.write = dec_wb_raw.write && (id_rd != '0);
    end

    // ID/EX
    logic                  idex_valid, idex_illegal, idex_use1, idex_use2;
    ctrl_ex_t              idex_ex;
    ctrl_mem_t             idex_mem;
    ctrl_wb_t              idex_wb;
    logic [REG_ADDR_W-1:0] idex_rs1, idex_rs2, idex_rd;
    // EX/MEM
    logic                  exmem_valid;
    ctrl_mem_t             exmem_mem;
    ctrl_wb_t              exmem_wb;
    logic [REG_ADDR_W-1:0] exmem_rd;
    // MEM/WB
    logic                  memwb_valid;
    ctrl_wb_t              memwb_wb;
    logic [REG_ADDR_W-1:0] memwb_rd;

    // True when the ID instruction reads register rd (x0 never matches).
    function automatic logic id_reads(input logic [REG_ADDR_W-1:0] rd);
        return (rd != '0) &&
               ((dec_use1 && (id_rs1 == rd)) || (dec_use2 && (id_rs2 == rd)));
    endfunction

    logic ex_load_hit, ex_write_hit, mem_write_hit, raw_hazard;

    assign ex_load_hit   = idex_valid  && idex_mem.load  && id_reads(idex_rd);
    assign ex_write_hit  = idex_valid  && idex_wb.write  && id_reads(idex_rd);
    assign mem_write_hit = exmem_valid && exmem_wb.write && id_reads(exmem_rd);

    // Without forwarding, any in-flight producer in EX or MEM must drain first;
    // WB is assumed to be visible through the register file in the same cycle.
    assign raw_hazard = FWD_ENABLE ? ex_load_hit : (ex_write_hit || mem_write_hit);
    assign stall      = id_valid && raw_hazard && !flush;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_ENABLE && idex_valid) begin
            if (idex_use1 && exmem_valid && exmem_wb.write && (exmem_rd == idex_rs1))
                fwd_a = FWD_EXMEM;
            else if (idex_use1 && memwb_valid && memwb_wb.write && (memwb_rd == idex_rs1))
                fwd_a = FWD_MEMWB;
            if (idex_use2 && exmem_valid && exmem_wb.write && (exmem_rd == idex_rs2))
                fwd_b = FWD_EXMEM;
            else if (idex_use2 && memwb_valid && memwb_wb.write && (memwb_rd == idex_rs2))
                fwd_b = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid   <= 1'b0;
            idex_illegal <= 1'b0;
            idex_use1    <= 1'b0;
            idex_use2    <= 1'b0;
            idex_ex      <= '0;
            idex_mem     <= '0;
            idex_wb      <= '0;
            idex_rs1     <= '0;
            idex_rs2     <= '0;
            idex_rd      <= '0;
            exmem_valid  <= 1'b0;
            exmem_mem    <= '0;
            exmem_wb     <= '0;
            exmem_rd     <= '0;
            memwb_valid  <= 1'b0;
            memwb_wb     <= '0;
            memwb_rd     <= '0;
        end else begin
            if (id_valid && !flush && !stall) begin
                idex_valid   <= 1'b1;
                idex_illegal <= dec_illegal;
                idex_use1    <= dec_use1;
                idex_use2    <= dec_use2;
                idex_ex      <= dec_ex;
                idex_mem     <= dec_mem;
                idex_wb      <= dec_wb;
                idex_rs1     <= id_rs1;
                idex_rs2     <= id_rs2;
                idex_rd      <= id_rd;
            end else begin
                // Bubble: everything zero so downstream stages see no control.
                idex_valid   <= 1'b0;
                idex_illegal <= 1'b0;
                idex_use1    <= 1'b0;
                idex_use2    <= 1'b0;
                idex_ex      <= '0;
                idex_mem     <= '0;
                idex_wb      <= '0;
                idex_rs1     <= '0;
                idex_rs2     <= '0;
                idex_rd      <= '0;
            end
            exmem_valid <= idex_valid;
            exmem_mem   <= idex_mem;
            exmem_wb    <= idex_wb;
            exmem_rd    <= idex_rd;
            memwb_valid <= exmem_valid;
            memwb_wb    <= exmem_wb;
            memwb_rd    <= exmem_rd;
        end
    end

    assign illegal  = idex_valid && idex_illegal;
    assign ex_ctrl  = idex_valid ? idex_ex : '0;
    assign mem_ctrl = exmem_valid ? exmem_mem : '0;
    assign wb_write = memwb_valid && memwb_wb.write;
    assign wb_load  = memwb_valid && memwb_wb.load;
    assign wb_rd    = memwb_valid ? memwb_rd : '0;

endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: two instances (forwarding on / off) share one stimulus
// stream; a slot-level model of the pipeline predicts every output each cycle.
module tb_control_pipeline;
    import ctrl_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [11:0] ex;
        logic        load, store, write, illegal, use1, use2;
        logic [4:0]  rs1, rs2, rd;
    } slot_t;

    typedef struct packed {
        logic       v;
        logic       fl;
        logic [8:0] c;
        logic [4:0] r1, r2, rd;
    } instr_t;

    localparam logic [8:0] C_R = 9'h001, C_LW = 9'h002, C_ADDI = 9'h004;
    localparam logic [8:0] C_LUI = 9'h080;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       id_valid = 1'b0, flush = 1'b0;
    logic [8:0] id_class = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic       stall0, illegal0, wb_write0, wb_load0;
    logic       stall1, illegal1, wb_write1, wb_load1;
    ctrl_ex_t   ex_ctrl0, ex_ctrl1;
    ctrl_mem_t  mem_ctrl0, mem_ctrl1;
    logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic [4:0] wb_rd0, wb_rd1;
    logic [26:0] obs0, obs1;

    control_pipeline #(.REG_ADDR_W(5), .FWD_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_class(id_class),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall0), .illegal(illegal0), .ex_ctrl(ex_ctrl0),
        .fwd_a(fwd_a0), .fwd_b(fwd_b0), .mem_ctrl(mem_ctrl0),
        .wb_write(wb_write0), .wb_load(wb_load0), .wb_rd(wb_rd0)
    );

    control_pipeline #(.REG_ADDR_W(5), .FWD_ENABLE(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_class(id_class),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall1), .illegal(illegal1), .ex_ctrl(ex_ctrl1),
        .fwd_a(fwd_a1), .fwd_b(fwd_b1), .mem_ctrl(mem_ctrl1),
        .wb_write(wb_write1), .wb_load(wb_load1), .wb_rd(wb_rd1)
    );

    assign obs0 = {stall0, illegal0, ex_ctrl0, fwd_a0, fwd_b0, mem_ctrl0, wb_write0, wb_load0, wb_rd0};
    assign obs1 = {stall1, illegal1, ex_ctrl1, fwd_a1, fwd_b1, mem_ctrl1, wb_write1, wb_load1, wb_rd1};

    // ---------------- reference model ----------------
    slot_t       m_ex[2], m_mem[2], m_wb[2];
    logic [26:0] exp_obs[2];
    logic [4:0]  exp_q[$];
    int          n_checks = 0, n_errors = 0;

    function automatic slot_t model_decode(input logic [8:0] c, input logic [4:0] r1, r2, rd);
        slot_t s;
        logic [1:0] a, npc;
        logic [2:0] imm, op;
        logic b, br, w;
        s = '0; a = 0; npc = 0; imm = 0; op = 0; b = 0; br = 0; w = 0;
        s.valid = 1'b1; s.rs1 = r1; s.rs2 = r2; s.rd = rd;
        case (c)
            9'h001: begin w = 1; op = 1; s.use1 = 1; s.use2 = 1; end                  // r
            9'h002: begin w = 1; s.load = 1; b = 1; s.use1 = 1; end                   // lw
            9'h004: begin w = 1; b = 1; op = 1; s.use1 = 1; end                       // addi
            9'h008: begin w = 1; b = 1; npc = 3; s.use1 = 1; end                      // jalr
            9'h010: begin s.store = 1; b = 1; imm = 1; s.use1 = 1; s.use2 = 1; end    // s
            9'h020: begin br = 1; imm = 2; npc = 1; op = 2; s.use1 = 1; s.use2 = 1; end // sb
            9'h040: begin w = 1; a = 1; b = 1; imm = 3; end                           // auipc
            9'h080: begin w = 1; a = 2; b = 1; imm = 3; end                           // lui
            9'h100: begin w = 1; a = 1; imm = 4; npc = 2; end                         // uj
            default: s.illegal = 1'b1;
        endcase
        s.write = w && (rd != 0);
        s.ex = {a, b, imm, npc, op, br};
        return s;
    endfunction

    function automatic logic reads(input slot_t d, input logic [4:0] r);
        return (r != 0) && ((d.use1 && d.rs1 == r) || (d.use2 && d.rs2 == r));
    endfunction

    function automatic logic model_stall(input int i);
        slot_t d;
        d = model_decode(id_class, id_rs1, id_rs2, id_rd);
        if (!id_valid || flush) return 1'b0;
        if (i == 0) return m_ex[0].valid && m_ex[0].load && reads(d, m_ex[0].rd);
        return (m_ex[1].valid && m_ex[1].write && reads(d, m_ex[1].rd)) ||
               (m_mem[1].valid && m_mem[1].write && reads(d, m_mem[1].rd));
    endfunction

    function automatic logic [1:0] model_fwd(input int i, input logic u, input logic [4:0] r);
        if (i != 0 || !m_ex[i].valid || !u) return 2'b00;
        if (m_mem[i].valid && m_mem[i].write && m_mem[i].rd == r) return 2'b01;
        if (m_wb[i].valid && m_wb[i].write && m_wb[i].rd == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [26:0] model_obs(input int i);
        slot_t e, m, w;
        e = m_ex[i]; m = m_mem[i]; w = m_wb[i];
        return {model_stall(i), e.valid & e.illegal, e.valid ? e.ex : 12'd0,
                model_fwd(i, e.use1, e.rs1), model_fwd(i, e.use2, e.rs2),
                m.valid ? {m.load, m.store} : 2'b00,
                w.valid & w.write, w.valid & w.load, w.valid ? w.rd : 5'd0};
    endfunction

    function automatic instr_t mk(input logic v, fl, input logic [8:0] c, input logic [4:0] r1, r2, rd);
        instr_t t;
        t.v = v; t.fl = fl; t.c = c; t.r1 = r1; t.r2 = r2; t.rd = rd;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input instr_t t);
        id_valid = t.v; flush = t.fl; id_class = t.c;
        id_rs1 = t.r1; id_rs2 = t.r2; id_rd = t.rd;
        #1;
        for (int i = 0; i < 2; i++) exp_obs[i] = model_obs(i);
    endtask

    task automatic clock_edge();
        slot_t d;
        logic  st;
        d = model_decode(id_class, id_rs1, id_rs2, id_rd);
        for (int i = 0; i < 2; i++) begin
            st = model_stall(i);
            if (rst) begin
                m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0;
            end else begin
                m_wb[i]  = m_mem[i];
                m_mem[i] = m_ex[i];
                m_ex[i]  = (id_valid && !flush && !st) ? d : '0;
            end
        end
        if (m_wb[0].valid && m_wb[0].write) exp_q.push_back(m_wb[0].rd);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0));
        clock_edge();
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0));
        n_checks++; if (obs0 !== 27'd0) begin n_errors++; $display("FAIL reset_fwd actual=%h required=%h", obs0, 27'd0); end
        n_checks++; if (obs1 !== 27'd0) begin n_errors++; $display("FAIL reset_nofwd actual=%h required=%h", obs1, 27'd0); end
        n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL reset_model actual=%h required=%h", obs0, exp_obs[0]); end
        clock_edge();
    endtask

    task automatic test_classes();
        instr_t seq[$];
        logic   exp_w;
        for (int i = 0; i < 9; i++) seq.push_back(mk(1, 0, 9'(1) << i, 1, 2, 5));
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < seq.size(); k++) begin
            drive(seq[k]);
            n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL classes_fwd k=%0d actual=%h required=%h", k, obs0, exp_obs[0]); end
            n_checks++; if (obs1 !== exp_obs[1]) begin n_errors++; $display("FAIL classes_nofwd k=%0d actual=%h required=%h", k, obs1, exp_obs[1]); end
            if (k >= 3) begin
                exp_w = !((k - 3) == 4 || (k - 3) == 5);
                n_checks++;
                if (wb_write0 !== exp_w || (exp_w && wb_rd0 !== 5'd5)) begin
                    n_errors++; $display("FAIL classes_wb k=%0d actual=%b/%0d required=%b/5", k, wb_write0, wb_rd0, exp_w);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_load_use();
        instr_t seq[$];
        seq.push_back(mk(1, 0, C_LW, 1, 0, 5));
        seq.push_back(mk(1, 0, C_R, 5, 7, 6));
        seq.push_back(mk(1, 0, C_R, 5, 7, 6));
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < seq.size(); k++) begin
            drive(seq[k]);
            n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL load_use_fwd k=%0d actual=%h required=%h", k, obs0, exp_obs[0]); end
            n_checks++; if (obs1 !== exp_obs[1]) begin n_errors++; $display("FAIL load_use_nofwd k=%0d actual=%h required=%h", k, obs1, exp_obs[1]); end
            if (k == 1) begin n_checks++; if (stall0 !== 1'b1) begin n_errors++; $display("FAIL load_use_stall actual=%b required=1", stall0); end end
            if (k == 2) begin n_checks++; if ({stall0, ex_ctrl0} !== 13'd0) begin n_errors++; $display("FAIL load_use_bubble actual=%h required=0", {stall0, ex_ctrl0}); end end
            if (k == 3) begin n_checks++; if ({fwd_a0, fwd_b0} !== 4'b1000) begin n_errors++; $display("FAIL load_use_fwd_sel actual=%b required=1000", {fwd_a0, fwd_b0}); end end
            clock_edge();
        end
    endtask

    task automatic test_forward();
        instr_t seq[$];
        seq.push_back(mk(1, 0, C_ADDI, 1, 0, 3));
        seq.push_back(mk(1, 0, C_R, 3, 3, 4));
        seq.push_back(mk(0, 0, 0, 0, 0, 0));
        seq.push_back(mk(0, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, C_ADDI, 1, 0, 3));
        seq.push_back(mk(1, 0, C_ADDI, 1, 0, 9));
        seq.push_back(mk(1, 0, C_R, 3, 3, 4));
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < seq.size(); k++) begin
            drive(seq[k]);
            n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL forward_fwd k=%0d actual=%h required=%h", k, obs0, exp_obs[0]); end
            n_checks++; if (obs1 !== exp_obs[1]) begin n_errors++; $display("FAIL forward_nofwd k=%0d actual=%h required=%h", k, obs1, exp_obs[1]); end
            if (k == 1) begin n_checks++; if (stall0 !== 1'b0) begin n_errors++; $display("FAIL forward_nostall actual=%b required=0", stall0); end end
            if (k == 2) begin n_checks++; if ({fwd_a0, fwd_b0} !== 4'b0101) begin n_errors++; $display("FAIL forward_exmem actual=%b required=0101", {fwd_a0, fwd_b0}); end end
            if (k == 7) begin n_checks++; if ({fwd_a0, fwd_b0} !== 4'b1010) begin n_errors++; $display("FAIL forward_memwb actual=%b required=1010", {fwd_a0, fwd_b0}); end end
            clock_edge();
        end
    endtask

    task automatic test_x0();
        instr_t seq[$];
        seq.push_back(mk(1, 0, C_LW, 1, 0, 0));
        seq.push_back(mk(1, 0, C_R, 0, 0, 6));
        seq.push_back(mk(0, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, C_LUI, 0, 0, 0));
        for (int i = 0; i < 4; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < seq.size(); k++) begin
            drive(seq[k]);
            n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL x0_fwd k=%0d actual=%h required=%h", k, obs0, exp_obs[0]); end
            n_checks++; if (obs1 !== exp_obs[1]) begin n_errors++; $display("FAIL x0_nofwd k=%0d actual=%h required=%h", k, obs1, exp_obs[1]); end
            if (k == 1) begin n_checks++; if ({stall0, stall1} !== 2'b00) begin n_errors++; $display("FAIL x0_stall actual=%b required=00", {stall0, stall1}); end end
            if (k == 2) begin n_checks++; if ({fwd_a0, fwd_b0} !== 4'b0000) begin n_errors++; $display("FAIL x0_fwd_sel actual=%b required=0000", {fwd_a0, fwd_b0}); end end
            if (k == 6) begin n_checks++; if (wb_write0 !== 1'b0) begin n_errors++; $display("FAIL x0_lui_wb actual=%b required=0", wb_write0); end end
            clock_edge();
        end
    endtask

    task automatic test_flush_illegal();
        instr_t seq[$];
        seq.push_back(mk(1, 0, C_LW, 1, 0, 5));
        seq.push_back(mk(1, 1, C_R, 5, 7, 6));
        seq.push_back(mk(0, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, 9'b000000011, 1, 2, 5));
        for (int i = 0; i < 4; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < seq.size(); k++) begin
            drive(seq[k]);
            n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL flush_fwd k=%0d actual=%h required=%h", k, obs0, exp_obs[0]); end
            n_checks++; if (obs1 !== exp_obs[1]) begin n_errors++; $display("FAIL flush_nofwd k=%0d actual=%h required=%h", k, obs1, exp_obs[1]); end
            if (k == 1) begin n_checks++; if ({stall0, stall1} !== 2'b00) begin n_errors++; $display("FAIL flush_stall actual=%b required=00", {stall0, stall1}); end end
            if (k == 2) begin n_checks++; if ({illegal0, ex_ctrl0} !== 13'd0) begin n_errors++; $display("FAIL flush_bubble actual=%h required=0", {illegal0, ex_ctrl0}); end end
            if (k == 4) begin n_checks++; if ({illegal0, illegal1} !== 2'b11) begin n_errors++; $display("FAIL illegal_flag actual=%b required=11", {illegal0, illegal1}); end end
            if (k == 6) begin n_checks++; if (wb_write0 !== 1'b0) begin n_errors++; $display("FAIL illegal_wb actual=%b required=0", wb_write0); end end
            clock_edge();
        end
    endtask

    task automatic test_nofwd();
        instr_t seq[$];
        seq.push_back(mk(1, 0, C_ADDI, 1, 0, 3));
        for (int i = 0; i < 3; i++) seq.push_back(mk(1, 0, C_R, 3, 0, 4));
        for (int i = 0; i < 4; i++) seq.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < seq.size(); k++) begin
            drive(seq[k]);
            n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL nofwd_fwd k=%0d actual=%h required=%h", k, obs0, exp_obs[0]); end
            n_checks++; if (obs1 !== exp_obs[1]) begin n_errors++; $display("FAIL nofwd_nofwd k=%0d actual=%h required=%h", k, obs1, exp_obs[1]); end
            if (k == 1 || k == 2) begin n_checks++; if (stall1 !== 1'b1) begin n_errors++; $display("FAIL nofwd_stall k=%0d actual=%b required=1", k, stall1); end end
            if (k == 3) begin n_checks++; if (stall1 !== 1'b0) begin n_errors++; $display("FAIL nofwd_release actual=%b required=0", stall1); end end
            if (k == 4) begin n_checks++; if ({fwd_a1, fwd_b1} !== 4'b0000) begin n_errors++; $display("FAIL nofwd_sel actual=%b required=0000", {fwd_a1, fwd_b1}); end end
            clock_edge();
        end
    endtask

    task automatic test_random();
        instr_t     t;
        logic [4:0] r;
        exp_q.delete();
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom_range(0, 63) == 0);
            t.v  = ($urandom_range(0, 7) != 0);
            t.fl = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) t.c = 9'($urandom_range(0, 511));
            else t.c = 9'(1) << $urandom_range(0, 8);
            t.r1 = 5'($urandom_range(0, 3));
            t.r2 = 5'($urandom_range(0, 3));
            t.rd = 5'($urandom_range(0, 3));
            drive(t);
            n_checks++; if (obs0 !== exp_obs[0]) begin n_errors++; $display("FAIL random_fwd k=%0d actual=%h required=%h", k, obs0, exp_obs[0]); end
            n_checks++; if (obs1 !== exp_obs[1]) begin n_errors++; $display("FAIL random_nofwd k=%0d actual=%h required=%h", k, obs1, exp_obs[1]); end
            n_checks++;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                if (wb_write0 !== 1'b1 || wb_rd0 !== r) begin
                    n_errors++; $display("FAIL random_wb k=%0d actual=%b/%0d required=1/%0d", k, wb_write0, wb_rd0, r);
                end
            end else if (wb_write0 !== 1'b0) begin
                n_errors++; $display("FAIL random_wb k=%0d actual=%b required=0", k, wb_write0);
            end
            clock_edge();
        end
        rst = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0;
        end
        @(negedge clk);
        test_reset();
        test_classes();
        test_load_use();
        test_forward();
        test_x0();
        test_flush_illegal();
        test_nofwd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
